// File: rtl/uart_cfg_pkg.sv
// uart_cfg_pkg: shared definitions for the configurable UART.
// Holds the parity mode encodings, the TX/RX FSM state type and the parity helper.
// No ports; imported by uart_cfg and uart_cfg_tick.
package uart_cfg_pkg;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_ODD  = 2'd1;
  localparam logic [1:0] PARITY_EVEN = 2'd2;

  // Both directions walk the same frame sequence, so they share one state type.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Parity bit on the line for a character whose data XOR-reduction is 'red'.
  function automatic logic parity_bit(input logic red, input logic [1:0] mode);
    return (mode == PARITY_ODD) ? ~red : red;
  endfunction

endpackage

// File: rtl/uart_cfg_tick.sv
// uart_cfg_tick: free-running 16x oversampling tick, one clk pulse every DIV clocks.
// Latency: first tick DIV clocks after reset release (every clock when DIV==1); no backpressure.
// Ports: clk, resetq (async active-low), o_tick (single-cycle pulse).
module uart_cfg_tick
  import uart_cfg_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic resetq,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : g_div_check
    $error("uart_cfg_tick: DIV must be >= 1 (CLKFREQ too low for 16*BAUD)");
  end

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cfg.sv
// uart_cfg: full-duplex UART with configurable data bits, parity, stop bits and an RX FIFO.
// Latency: tx start bit on the first tick after an accepted wr; RX char visible 2 clk after its stop sample.
// Backpressure: wr ignored while busy; RX chars arriving to a full FIFO are dropped and set sticky overrun.
// Ports: clk/resetq; rx/tx serial pins; wr/tx_data/busy TX side; rd/valid/rx_data/frame_err/
//        parity_err/rx_count RX FIFO head and occupancy; overrun sticky flag cleared by clr_err.
module uart_cfg
  import uart_cfg_pkg::*;
#(
  parameter int CLKFREQ       = 12000000,
  parameter int BAUD          = 115200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             resetq,
  input  logic                             rx,
  output logic                             tx,
  input  logic                             wr,
  input  logic [DATA_BITS-1:0]             tx_data,
  output logic                             busy,
  input  logic                             rd,
  output logic                             valid,
  output logic [DATA_BITS-1:0]             rx_data,
  output logic                             frame_err,
  output logic                             parity_err,
  output logic [$clog2(RX_FIFO_DEPTH):0]   rx_count,
  output logic                             overrun,
  input  logic                             clr_err
);

  localparam int DIV        = CLKFREQ / (16 * BAUD);
  localparam int AW         = $clog2(RX_FIFO_DEPTH);
  localparam int EW         = DATA_BITS + 2;
  localparam int STOP_TICKS = STOP_BITS * 16;
  localparam logic [1:0] PMODE = 2'(PARITY);

  logic w_tick;

  uart_cfg_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .resetq (resetq),
    .o_tick (w_tick)
  );

  // ---------------- TX ----------------
  uart_state_t          r_tx_state;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic [4:0]           r_tx_tcnt;
  logic [3:0]           r_tx_bit;
  logic                 r_tx;
  logic                 r_busy;

  // Each bit is driven onto the pin on its first tick and held for 16 ticks
  // (STOP_TICKS for the stop phase); the state advances on the bit's last tick.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_tx_state <= ST_IDLE;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx_tcnt  <= '0;
      r_tx_bit   <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      case (r_tx_state)
        ST_IDLE: begin
          if (wr) begin
            r_tx_shift <= tx_data;
            r_tx_par   <= parity_bit(^tx_data, PMODE);
            r_busy     <= 1'b1;
            r_tx_tcnt  <= '0;
            r_tx_bit   <= '0;
            r_tx_state <= ST_START;
          end
        end
        default: begin
          if (w_tick) begin
            r_tx_tcnt <= r_tx_tcnt + 1'b1;
            if (r_tx_tcnt == 5'd0) begin
              case (r_tx_state)
                ST_START:  r_tx <= 1'b0;
                ST_DATA:   r_tx <= r_tx_shift[0];
                ST_PARITY: r_tx <= r_tx_par;
                default:   r_tx <= 1'b1;
              endcase
            end
            if ((r_tx_state == ST_STOP) ? (r_tx_tcnt == 5'(STOP_TICKS - 1))
                                        : (r_tx_tcnt == 5'd15)) begin
              r_tx_tcnt <= '0;
              case (r_tx_state)
                ST_START: r_tx_state <= ST_DATA;
                ST_DATA: begin
                  r_tx_shift <= r_tx_shift >> 1;
                  r_tx_bit   <= r_tx_bit + 1'b1;
                  if (r_tx_bit == 4'(DATA_BITS - 1)) begin
                    r_tx_state <= (PMODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                  end
                end
                ST_PARITY: r_tx_state <= ST_STOP;
                default: begin
                  r_tx_state <= ST_IDLE;
                  r_busy     <= 1'b0;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;

  // ---------------- RX ----------------
  uart_state_t          r_rx_state;
  logic                 r_rx_s1, r_rx_s2, r_rx_prev;
  logic [3:0]           r_rx_ocnt;
  logic [3:0]           r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_perr;
  logic                 r_push;
  logic [EW-1:0]        r_push_dat;
  logic                 w_rx_sample;

  // Oversample counter starts at 0 on the detected falling edge, so the 8th tick
  // (count 7) lands mid start bit and every 16 ticks after that lands mid-bit.
  assign w_rx_sample = w_tick && (r_rx_ocnt == 4'd7);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= ST_IDLE;
      r_rx_ocnt  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_perr  <= 1'b0;
      r_push     <= 1'b0;
      r_push_dat <= '0;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      r_push    <= 1'b0;
      if (r_rx_state == ST_IDLE) begin
        if (r_rx_prev && !r_rx_s2) begin
          r_rx_state <= ST_START;
          r_rx_ocnt  <= '0;
        end
      end else begin
        if (w_tick) r_rx_ocnt <= r_rx_ocnt + 1'b1;
        if (w_rx_sample) begin
          case (r_rx_state)
            ST_START: begin
              if (!r_rx_s2) begin
                r_rx_state <= ST_DATA;
                r_rx_bit   <= '0;
                r_rx_perr  <= 1'b0;
              end else begin
                r_rx_state <= ST_IDLE;  // glitch, not a start bit
              end
            end
            ST_DATA: begin
              r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
              r_rx_bit   <= r_rx_bit + 1'b1;
              if (r_rx_bit == 4'(DATA_BITS - 1)) begin
                r_rx_state <= (PMODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
              end
            end
            ST_PARITY: begin
              r_rx_perr  <= (r_rx_s2 != parity_bit(^r_rx_shift, PMODE));
              r_rx_state <= ST_STOP;
            end
            default: begin
              // Only the first stop bit is checked; re-arming here lets a
              // 1-stop sender follow immediately even when STOP_BITS==2.
              r_push     <= 1'b1;
              r_push_dat <= {r_rx_perr, ~r_rx_s2, r_rx_shift};
              r_rx_state <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

  // ---------------- RX FIFO ----------------
  logic [EW-1:0] r_mem [RX_FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_ovr;
  logic          w_full, w_pop, w_wr;
  logic [EW-1:0] w_head;

  assign w_full = (r_count == (AW + 1)'(RX_FIFO_DEPTH));
  assign w_pop  = rd && (r_count != '0);
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign w_wr   = r_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_push_dat;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A fresh overrun wins over clr_err in the same cycle.
      r_ovr <= (r_push && w_full && !w_pop) || (r_ovr && !clr_err);
    end
  end

  assign w_head = r_mem[r_rptr];

  always_comb begin
    valid      = (r_count != '0);
    rx_data    = '0;
    frame_err  = 1'b0;
    parity_err = 1'b0;
    if (valid) begin
      rx_data    = w_head[DATA_BITS-1:0];
      frame_err  = w_head[DATA_BITS];
      parity_err = w_head[DATA_BITS+1];
    end
  end

  assign rx_count = r_count;
  assign overrun  = r_ovr;

endmodule

// File: tb/tb_uart_cfg.sv
`timescale 1ns/1ps
module tb_uart_cfg;

  localparam int CLK_HZ = 1843200;
  localparam int BAUD_R = 115200;

  logic clk = 1'b0;
  logic resetq = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 8N1, depth 4: TX waveform, RX frame errors, overrun, mid-frame reset
  logic       n1_rx = 1'b1, n1_wr = 1'b0, n1_rd = 1'b0, n1_clr = 1'b0;
  logic [7:0] n1_txd = 8'h00;
  logic       n1_tx, n1_busy, n1_valid, n1_fe, n1_pe, n1_ovr;
  logic [7:0] n1_rxd;
  logic [2:0] n1_cnt;
  // 8E2 in loopback
  logic       e2_wr = 1'b0, e2_rd = 1'b0, e2_clr = 1'b0;
  logic [7:0] e2_txd = 8'h00;
  logic       e2_tx, e2_busy, e2_valid, e2_fe, e2_pe, e2_ovr;
  logic [7:0] e2_rxd;
  logic [2:0] e2_cnt;
  // 8O1 for parity-error frames
  logic       o1_rx = 1'b1, o1_wr = 1'b0, o1_rd = 1'b0, o1_clr = 1'b0;
  logic [7:0] o1_txd = 8'h00;
  logic       o1_tx, o1_busy, o1_valid, o1_fe, o1_pe, o1_ovr;
  logic [7:0] o1_rxd;
  logic [2:0] o1_cnt;

  uart_cfg #(.CLKFREQ(CLK_HZ), .BAUD(BAUD_R), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) u_n1 (
    .clk(clk), .resetq(resetq), .rx(n1_rx), .tx(n1_tx), .wr(n1_wr), .tx_data(n1_txd), .busy(n1_busy),
    .rd(n1_rd), .valid(n1_valid), .rx_data(n1_rxd), .frame_err(n1_fe), .parity_err(n1_pe),
    .rx_count(n1_cnt), .overrun(n1_ovr), .clr_err(n1_clr));

  uart_cfg #(.CLKFREQ(CLK_HZ), .BAUD(BAUD_R), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .RX_FIFO_DEPTH(4)) u_e2 (
    .clk(clk), .resetq(resetq), .rx(e2_tx), .tx(e2_tx), .wr(e2_wr), .tx_data(e2_txd), .busy(e2_busy),
    .rd(e2_rd), .valid(e2_valid), .rx_data(e2_rxd), .frame_err(e2_fe), .parity_err(e2_pe),
    .rx_count(e2_cnt), .overrun(e2_ovr), .clr_err(e2_clr));

  uart_cfg #(.CLKFREQ(CLK_HZ), .BAUD(BAUD_R), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) u_o1 (
    .clk(clk), .resetq(resetq), .rx(o1_rx), .tx(o1_tx), .wr(o1_wr), .tx_data(o1_txd), .busy(o1_busy),
    .rd(o1_rd), .valid(o1_valid), .rx_data(o1_rxd), .frame_err(o1_fe), .parity_err(o1_pe),
    .rx_count(o1_cnt), .overrun(o1_ovr), .clr_err(o1_clr));

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line-level frame model: start 0, data LSB first, optional parity, stop bits.
  // Odd parity makes the total count of ones (data + parity) odd, even makes it even.
  function automatic int build_frame(input logic [7:0] d, input int par, input int stops,
                                     input bit flip_par, input bit low_stop, output logic [15:0] f);
    int n;
    f = '1;
    n = 0;
    f[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin f[n] = d[i]; n++; end
    if (par != 0) begin
      f[n] = (par == 1) ? (($countones(d) % 2) == 0) : (($countones(d) % 2) == 1);
      if (flip_par) f[n] = ~f[n];
      n++;
    end
    for (int s = 0; s < stops; s++) begin
      f[n] = (s == 0) ? !low_stop : 1'b1;
      n++;
    end
    return n;
  endfunction

  task automatic drive_frame(input int which, input logic [15:0] f, input int n);
    for (int b = 0; b < n; b++) begin
      if (which == 0) n1_rx = f[b]; else o1_rx = f[b];
      repeat (16) step();
    end
    n1_rx = 1'b1;
    o1_rx = 1'b1;
  endtask

  // Bench-side receiver for the n1 tx pin: find start, sample every 16 clk mid-bit.
  task automatic decode_n1(output logic [7:0] d, output bit ok);
    int t;
    d = '0; ok = 1'b0; t = 0;
    while (n1_tx !== 1'b0 && t < 400) begin step(); t++; end
    if (t < 400) begin
      repeat (8) step();
      if (n1_tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin repeat (16) step(); d[i] = n1_tx; end
        repeat (16) step();
        ok = (n1_tx === 1'b1);
      end
    end
  endtask

  task automatic test_reset();
    resetq = 1'b0;
    repeat (3) step();
    n_checks++; if (n1_tx !== 1'b1)     begin n_fail++; $display("FAIL reset_tx: got %b want 1", n1_tx); end
    n_checks++; if (n1_busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b want 0", n1_busy); end
    n_checks++; if (n1_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b want 0", n1_valid); end
    n_checks++; if (n1_cnt !== 3'd0)    begin n_fail++; $display("FAIL reset_count: got %0d want 0", n1_cnt); end
    n_checks++; if (n1_rxd !== 8'h00)   begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", n1_rxd); end
    n_checks++; if ({n1_fe, n1_pe, n1_ovr} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {n1_fe, n1_pe, n1_ovr}); end
    resetq = 1'b1;
    repeat (4) step();
    n_checks++; if ({e2_tx, e2_busy, e2_valid} !== 3'b100) begin n_fail++; $display("FAIL reset_e2: got %b want 100", {e2_tx, e2_busy, e2_valid}); end
    n_checks++; if ({o1_tx, o1_busy, o1_valid} !== 3'b100) begin n_fail++; $display("FAIL reset_o1: got %b want 100", {o1_tx, o1_busy, o1_valid}); end
  endtask

  task automatic test_tx_a5();
    logic [15:0] f;
    int n, busy_cnt, bad_idle;
    n = build_frame(8'hA5, 0, 1, 1'b0, 1'b0, f);
    n1_txd = 8'hA5; n1_wr = 1'b1;
    step();
    n1_wr = 1'b0; n1_txd = 8'h00;
    busy_cnt = (n1_busy === 1'b1) ? 1 : 0;
    n_checks++; if (n1_tx !== 1'b1) begin n_fail++; $display("FAIL a5_before_tick: tx got %b want 1", n1_tx); end
    for (int k = 1; k <= 16 * n; k++) begin
      if (k == 50) n1_wr = 1'b1;  // must be ignored: busy
      if (k == 51) n1_wr = 1'b0;
      step();
      if (n1_busy === 1'b1) busy_cnt++;
      n_checks++;
      if (n1_tx !== f[(k - 1) / 16]) begin n_fail++; $display("FAIL a5_wave clk %0d: tx got %b want %b", k, n1_tx, f[(k - 1) / 16]); end
    end
    n_checks++; if (busy_cnt != 160) begin n_fail++; $display("FAIL a5_busy_len: got %0d want 160", busy_cnt); end
    n_checks++; if (n1_busy !== 1'b0) begin n_fail++; $display("FAIL a5_busy_end: got %b want 0", n1_busy); end
    bad_idle = 0;
    repeat (40) begin step(); if (n1_tx !== 1'b1 || n1_busy !== 1'b0) bad_idle++; end
    n_checks++; if (bad_idle != 0) begin n_fail++; $display("FAIL ignored_wr: %0d non-idle clk want 0", bad_idle); end
  endtask

  task automatic test_tx_random();
    logic [7:0] d, got;
    bit ok;
    int t;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      n1_txd = d; n1_wr = 1'b1; step(); n1_wr = 1'b0;
      decode_n1(got, ok);
      n_checks++; if (!ok || got !== d) begin n_fail++; $display("FAIL tx_rand %0d: got %h ok=%0d want %h", i, got, ok, d); end
      t = 0;
      while (n1_busy === 1'b1 && t < 100) begin step(); t++; end
      n_checks++; if (t >= 100) begin n_fail++; $display("FAIL tx_rand_busy %0d: busy stuck 1 want 0", i); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1, d2, got;
    bit ok;
    int t;
    d1 = 8'($urandom_range(0, 255));
    d2 = 8'($urandom_range(0, 255));
    n1_txd = d1; n1_wr = 1'b1; step(); n1_wr = 1'b0;
    decode_n1(got, ok);
    n_checks++; if (!ok || got !== d1) begin n_fail++; $display("FAIL b2b_first: got %h want %h", got, d1); end
    t = 0;
    while (n1_busy === 1'b1 && t < 100) begin step(); t++; end
    n1_txd = d2; n1_wr = 1'b1; step(); n1_wr = 1'b0;
    n_checks++; if (n1_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy got %b want 1", n1_busy); end
    decode_n1(got, ok);
    n_checks++; if (!ok || got !== d2) begin n_fail++; $display("FAIL b2b_second: got %h want %h", got, d2); end
    t = 0;
    while (n1_busy === 1'b1 && t < 100) begin step(); t++; end
  endtask

  task automatic test_loopback_e2();
    logic [7:0] d;
    int t;
    for (int i = 0; i < 5; i++) begin
      d = (i == 0) ? 8'h37 : 8'($urandom_range(0, 255));
      e2_txd = d; e2_wr = 1'b1; step(); e2_wr = 1'b0;
      t = 0;
      while (e2_valid !== 1'b1 && t < 400) begin step(); t++; end
      n_checks++; if (e2_valid !== 1'b1) begin n_fail++; $display("FAIL e2_valid %0d: got %b want 1", i, e2_valid); end
      n_checks++; if (e2_rxd !== d) begin n_fail++; $display("FAIL e2_data %0d: got %h want %h", i, e2_rxd, d); end
      n_checks++; if ({e2_pe, e2_fe} !== 2'b00) begin n_fail++; $display("FAIL e2_flags %0d: got %b want 00", i, {e2_pe, e2_fe}); end
      e2_rd = 1'b1; step(); e2_rd = 1'b0;
      n_checks++; if (e2_valid !== 1'b0) begin n_fail++; $display("FAIL e2_pop %0d: valid got %b want 0", i, e2_valid); end
      t = 0;
      while (e2_busy === 1'b1 && t < 100) begin step(); t++; end
    end
  endtask

  task automatic test_parity_o1();
    logic [15:0] f;
    logic [7:0] d;
    bit flip;
    int n;
    for (int i = 0; i < 8; i++) begin
      d    = (i < 2) ? 8'h01 : 8'($urandom_range(0, 255));
      flip = (i < 2) ? bit'(i) : bit'($urandom_range(0, 1));
      n = build_frame(d, 1, 1, flip, 1'b0, f);
      drive_frame(1, f, n);
      repeat (2) step();
      n_checks++; if (o1_valid !== 1'b1 || o1_rxd !== d) begin n_fail++; $display("FAIL par_data %0d: valid %b data %h want 1 %h", i, o1_valid, o1_rxd, d); end
      n_checks++; if (o1_pe !== flip) begin n_fail++; $display("FAIL par_err %0d: got %b want %b", i, o1_pe, flip); end
      n_checks++; if (o1_fe !== 1'b0) begin n_fail++; $display("FAIL par_fe %0d: got %b want 0", i, o1_fe); end
      o1_rd = 1'b1; step(); o1_rd = 1'b0;
    end
  endtask

  task automatic test_frame_glitch();
    logic [15:0] f;
    int n;
    n = build_frame(8'h55, 0, 1, 1'b0, 1'b1, f);
    drive_frame(0, f, n);
    repeat (16) step();
    n_checks++; if (n1_valid !== 1'b1 || n1_rxd !== 8'h55) begin n_fail++; $display("FAIL fe_data: valid %b data %h want 1 55", n1_valid, n1_rxd); end
    n_checks++; if ({n1_fe, n1_pe} !== 2'b10) begin n_fail++; $display("FAIL fe_flags: got %b want 10", {n1_fe, n1_pe}); end
    n1_rd = 1'b1; step(); n1_rd = 1'b0;
    n_checks++; if (n1_fe !== 1'b0) begin n_fail++; $display("FAIL fe_empty: frame_err got %b want 0", n1_fe); end
    n1_rx = 1'b0; repeat (5) step(); n1_rx = 1'b1;
    repeat (200) step();
    n_checks++; if (n1_valid !== 1'b0 || n1_cnt !== 3'd0) begin n_fail++; $display("FAIL glitch: valid %b count %0d want 0 0", n1_valid, n1_cnt); end
  endtask

  task automatic test_overrun();
    logic [15:0] f;
    logic [7:0] q [5];
    int n;
    for (int i = 0; i < 5; i++) begin
      q[i] = 8'($urandom_range(0, 255));
      n = build_frame(q[i], 0, 1, 1'b0, 1'b0, f);
      drive_frame(0, f, n);
    end
    repeat (4) step();
    n_checks++; if (n1_cnt !== 3'd4) begin n_fail++; $display("FAIL ovr_count: got %0d want 4", n1_cnt); end
    n_checks++; if (n1_ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", n1_ovr); end
    n_checks++; if (n1_rxd !== q[0]) begin n_fail++; $display("FAIL ovr_head: got %h want %h", n1_rxd, q[0]); end
    n1_clr = 1'b1; step(); n1_clr = 1'b0;
    n_checks++; if (n1_ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", n1_ovr); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (n1_valid !== 1'b1 || n1_rxd !== q[i]) begin n_fail++; $display("FAIL ovr_order %0d: valid %b data %h want 1 %h", i, n1_valid, n1_rxd, q[i]); end
      n1_rd = 1'b1; step(); n1_rd = 1'b0;
    end
    n_checks++; if (n1_valid !== 1'b0 || n1_cnt !== 3'd0 || n1_rxd !== 8'h00) begin n_fail++; $display("FAIL ovr_drained: valid %b count %0d data %h want 0 0 00", n1_valid, n1_cnt, n1_rxd); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] f;
    logic [7:0] d, got;
    bit ok;
    int n;
    n = build_frame(8'($urandom_range(0, 255)), 0, 1, 1'b0, 1'b0, f);
    drive_frame(0, f, n);
    repeat (2) step();
    n1_txd = 8'($urandom_range(0, 255)); n1_wr = 1'b1; n1_rx = 1'b0;
    step();
    n1_wr = 1'b0;
    repeat (40) step();
    n_checks++; if ({n1_busy, n1_valid} !== 2'b11) begin n_fail++; $display("FAIL mid_pre: busy,valid got %b want 11", {n1_busy, n1_valid}); end
    resetq = 1'b0;
    #1;
    n_checks++; if ({n1_tx, n1_busy, n1_valid} !== 3'b100) begin n_fail++; $display("FAIL mid_reset: tx,busy,valid got %b want 100", {n1_tx, n1_busy, n1_valid}); end
    n_checks++; if (n1_cnt !== 3'd0) begin n_fail++; $display("FAIL mid_reset_count: got %0d want 0", n1_cnt); end
    n1_rx = 1'b1;
    repeat (3) step();
    resetq = 1'b1;
    repeat (4) step();
    d = 8'($urandom_range(0, 255));
    n = build_frame(d, 0, 1, 1'b0, 1'b0, f);
    drive_frame(0, f, n);
    repeat (2) step();
    n_checks++; if (n1_cnt !== 3'd1 || n1_rxd !== d || n1_fe !== 1'b0) begin n_fail++; $display("FAIL post_rx: count %0d data %h fe %b want 1 %h 0", n1_cnt, n1_rxd, n1_fe, d); end
    n1_rd = 1'b1; step(); n1_rd = 1'b0;
    d = 8'($urandom_range(0, 255));
    n1_txd = d; n1_wr = 1'b1; step(); n1_wr = 1'b0;
    decode_n1(got, ok);
    n_checks++; if (!ok || got !== d) begin n_fail++; $display("FAIL post_tx: got %h ok=%0d want %h", got, ok, d); end
    repeat (20) step();
  endtask

  initial begin
    test_reset();
    test_tx_a5();
    test_tx_random();
    test_back_to_back();
    test_loopback_e2();
    test_parity_o1();
    test_frame_glitch();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
